// File: rtl/pd_switch_sequencer_if.sv
// Control/status bundle between power_manager, the sequencer and the header-switch chain.
// master = power_manager side (drives requests), slave = sequencer (drives switch/status).
interface pd_switch_sequencer_if #(
  parameter int N_SEG = 4
);
  logic             power_switch_enable;
  logic             isolation_enable;
  logic             state_retention_enable;
  logic [N_SEG-1:0] seg_on;
  logic             power_good;
  logic             power_off;
  logic             iso_err;
  logic             ret_err;

  modport master (
    output power_switch_enable, isolation_enable, state_retention_enable,
    input  seg_on, power_good, power_off, iso_err, ret_err
  );

  modport slave (
    input  power_switch_enable, isolation_enable, state_retention_enable,
    output seg_on, power_good, power_off, iso_err, ret_err
  );
endinterface

// File: rtl/pd_switch_sequencer.sv
// Inrush-limiting power-switch sequencer: stages segments off/on one per STEP cycles,
// reports settled/off status and latches isolation/retention protocol violations.
module pd_switch_sequencer #(
  parameter int N_SEG  = 4,
  parameter int STEP   = 4,
  parameter int SETTLE = 8
) (
  input logic                clk,
  input logic                reset,
  pd_switch_sequencer_if.slave bus
);
  localparam int MAXC = (STEP > SETTLE) ? STEP : SETTLE;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    STEP_M1 = CW'(STEP - 1);
  localparam logic [CW-1:0]    SET_M1  = CW'(SETTLE - 1);
  localparam logic [N_SEG-1:0] ALL_ON  = '1;

  typedef enum logic [2:0] {S_ON, S_RDN, S_OFF, S_RUP, S_SET} state_t;

  state_t           state_q, state_d;
  logic [N_SEG-1:0] seg_q, seg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pg_q, pg_d, poff_q, poff_d, iso_q, iso_d, ret_q, ret_d;
  logic             pse, all_on;

  assign pse    = bus.power_switch_enable;
  assign all_on = (seg_q == ALL_ON);

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;
    pg_d    = pg_q;
    poff_d  = poff_q;
    // Checks look at the registered segment state, never at this edge's update.
    iso_d   = iso_q | (~all_on & bus.isolation_enable);
    ret_d   = ret_q | (~all_on & ~bus.state_retention_enable);
    case (state_q)
      S_ON: if (pse) begin
        state_d = S_RDN;
        cnt_d   = '0;
        pg_d    = 1'b0;
      end
      S_RDN: begin
        if (!pse) begin
          state_d = S_RUP;
          cnt_d   = '0;
        end else if (cnt_q == STEP_M1) begin
          cnt_d = '0;
          // Thermometer code: shifting right drops the highest conducting segment.
          seg_d = seg_q >> 1;
          if ((seg_q >> 1) == '0) begin
            state_d = S_OFF;
            poff_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_OFF: if (!pse) begin
        state_d = S_RUP;
        cnt_d   = '0;
        poff_d  = 1'b0;
      end
      S_RUP: begin
        if (pse) begin
          state_d = S_RDN;
          cnt_d   = '0;
        end else if (all_on) begin
          state_d = S_SET;
          cnt_d   = '0;
        end else if (cnt_q == STEP_M1) begin
          cnt_d = '0;
          seg_d = {seg_q[N_SEG-2:0], 1'b1};
          if ({seg_q[N_SEG-2:0], 1'b1} == ALL_ON) state_d = S_SET;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SET: begin
        if (pse) begin
          state_d = S_RDN;
          cnt_d   = '0;
        end else if (cnt_q == SET_M1) begin
          state_d = S_ON;
          cnt_d   = '0;
          pg_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_ON;
        seg_d   = ALL_ON;
        cnt_d   = '0;
        pg_d    = 1'b1;
        poff_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ON;
      seg_q   <= ALL_ON;
      cnt_q   <= '0;
      pg_q    <= 1'b1;
      poff_q  <= 1'b0;
      iso_q   <= 1'b0;
      ret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      pg_q    <= pg_d;
      poff_q  <= poff_d;
      iso_q   <= iso_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.seg_on     = seg_q;
  assign bus.power_good = pg_q;
  assign bus.power_off  = poff_q;
  assign bus.iso_err    = iso_q;
  assign bus.ret_err    = ret_q;
endmodule

// File: tb/tb_pd_switch_sequencer.sv
// Bench for pd_switch_sequencer: level/timestamp model checked every cycle, plus
// directed scenarios with literal expectations at the key edges.
module tb_pd_switch_sequencer;
  localparam int N = 4, STEP = 4, SETTLE = 8;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0, fails = 0;

  pd_switch_sequencer_if #(.N_SEG(N)) bus ();
  pd_switch_sequencer #(.N_SEG(N), .STEP(STEP), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: number of conducting segments, requested direction, time of last reversal,
  // time the domain became fully on.
  int   cyc = 0;
  int   m_lvl, m_t0, m_tfull;
  logic m_goff, m_pg, m_poff, m_iso, m_ret, m_ok = 1'b0;

  always @(posedge clk) begin
    automatic int   lv = m_lvl, t0 = m_t0, tf = m_tfull, el;
    automatic logic go = m_goff, pg = m_pg, po = m_poff, ie = m_iso, re = m_ret;
    if (reset) begin
      lv = N; pg = 1'b1; po = 1'b0; ie = 1'b0; re = 1'b0; go = 1'b0; t0 = cyc; tf = cyc;
      m_ok <= 1'b1;
    end else if (m_ok) begin
      ie = ie | (lv < N && bus.isolation_enable);
      re = re | (lv < N && !bus.state_retention_enable);
      if (bus.power_switch_enable != go) begin
        go = bus.power_switch_enable;
        t0 = cyc;
        if (go) pg = 1'b0;
        else begin
          po = 1'b0;
          if (lv == N) tf = cyc + 1;
        end
      end else begin
        el = cyc - t0;
        if (go && lv > 0 && el > 0 && el % STEP == 0) begin
          lv = lv - 1;
          if (lv == 0) po = 1'b1;
        end else if (!go && lv < N && el > 0 && el % STEP == 0) begin
          lv = lv + 1;
          if (lv == N) tf = cyc;
        end else if (!go && lv == N && !pg && cyc - tf == SETTLE) begin
          pg = 1'b1;
        end
      end
    end
    m_lvl <= lv; m_t0 <= t0; m_tfull <= tf; m_goff <= go;
    m_pg <= pg; m_poff <= po; m_iso <= ie; m_ret <= re;
    cyc <= cyc + 1;
  end

  function automatic logic [N-1:0] therm(input int l);
    logic [N-1:0] t;
    for (int i = 0; i < N; i++) t[i] = (i < l);
    return t;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      tests++;
      if (bus.seg_on !== therm(m_lvl) || bus.power_good !== m_pg || bus.power_off !== m_poff ||
          bus.iso_err !== m_iso || bus.ret_err !== m_ret) begin
        fails++;
        $display("FAIL model cyc=%0d: dut seg=%b pg=%b off=%b iso=%b ret=%b, need seg=%b pg=%b off=%b iso=%b ret=%b",
                 cyc, bus.seg_on, bus.power_good, bus.power_off, bus.iso_err, bus.ret_err,
                 therm(m_lvl), m_pg, m_poff, m_iso, m_ret);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, need %0h", nm, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.power_switch_enable    = 1'b0;
    bus.isolation_enable       = 1'b0;
    bus.state_retention_enable = 1'b1;
    tick(3);
    chk("reset_seg", bus.seg_on, 32'hF);
    chk("reset_pg", bus.power_good, 1);
    chk("reset_off", bus.power_off, 0);
    chk("reset_err", {bus.iso_err, bus.ret_err}, 0);
    reset = 1'b0;
    tick(2);

    // Power-down
    bus.power_switch_enable = 1'b1;
    tick(1);
    chk("dn_pg_E0", bus.power_good, 0);
    tick(4); chk("dn_seg_4", bus.seg_on, 32'h7);
    tick(4); chk("dn_seg_8", bus.seg_on, 32'h3);
    tick(4); chk("dn_seg_12", bus.seg_on, 32'h1);
    tick(3); chk("dn_off_15", bus.power_off, 0);
    tick(1); chk("dn_seg_16", bus.seg_on, 32'h0);
    chk("dn_off_16", bus.power_off, 1);
    chk("dn_noerr", {bus.iso_err, bus.ret_err}, 0);
    tick(3);

    // Power-up from OFF
    bus.power_switch_enable = 1'b0;
    tick(1); chk("up_off_E0", bus.power_off, 0);
    tick(4); chk("up_seg_4", bus.seg_on, 32'h1);
    tick(4); chk("up_seg_8", bus.seg_on, 32'h3);
    tick(4); chk("up_seg_12", bus.seg_on, 32'h7);
    tick(4); chk("up_seg_16", bus.seg_on, 32'hF);
    tick(7); chk("up_pg_23", bus.power_good, 0);
    tick(1); chk("up_pg_24", bus.power_good, 1);
    tick(2);

    // Mid-ramp reversal
    bus.power_switch_enable = 1'b1;
    tick(1);
    tick(8); chk("rev_seg_8", bus.seg_on, 32'h3);
    bus.power_switch_enable = 1'b0;
    tick(1); chk("rev_seg_9", bus.seg_on, 32'h3);
    tick(3); chk("rev_seg_12", bus.seg_on, 32'h3);
    tick(1); chk("rev_seg_13", bus.seg_on, 32'h7);
    tick(4); chk("rev_seg_17", bus.seg_on, 32'hF);
    tick(7); chk("rev_pg_24", bus.power_good, 0);
    tick(1); chk("rev_pg_25", bus.power_good, 1);
    tick(2);

    // One-cycle request glitch
    bus.power_switch_enable = 1'b1;
    tick(1); chk("gl_pg_E0", bus.power_good, 0);
    bus.power_switch_enable = 1'b0;
    tick(9); chk("gl_pg_9", bus.power_good, 0);
    chk("gl_seg_9", bus.seg_on, 32'hF);
    tick(1); chk("gl_pg_10", bus.power_good, 1);
    tick(2);

    // Protocol violations
    bus.power_switch_enable = 1'b1;
    tick(1);
    tick(4); chk("pv_seg_4", bus.seg_on, 32'h7);
    bus.isolation_enable = 1'b1;
    tick(1); chk("pv_iso", bus.iso_err, 1);
    chk("pv_ret_clean", bus.ret_err, 0);
    bus.isolation_enable = 1'b0;
    tick(11); chk("pv_seg_16", bus.seg_on, 32'h0);
    chk("pv_off_16", bus.power_off, 1);
    bus.state_retention_enable = 1'b0;
    tick(1); chk("pv_ret", bus.ret_err, 1);
    bus.state_retention_enable = 1'b1;
    tick(3);
    bus.power_switch_enable = 1'b0;
    tick(25); chk("pv_pg_back", bus.power_good, 1);
    chk("pv_sticky", {bus.iso_err, bus.ret_err}, 32'h3);

    // Reset mid ramp-down
    bus.power_switch_enable = 1'b1;
    tick(1);
    tick(8); chk("rst_seg_pre", bus.seg_on, 32'h3);
    reset = 1'b1;
    bus.power_switch_enable = 1'b0;
    tick(1);
    chk("rst_seg", bus.seg_on, 32'hF);
    chk("rst_pg", bus.power_good, 1);
    chk("rst_off", bus.power_off, 0);
    chk("rst_err", {bus.iso_err, bus.ret_err}, 0);
    reset = 1'b0;
    tick(3);
    chk("rst_hold", {bus.seg_on, bus.power_good}, 32'h1F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pd_switch_sequencer.md
# pd_switch_sequencer

Power-switch inrush sequencer sitting directly downstream of `power_manager`. It consumes `power_switch_enable`, `isolation_enable` and `state_retention_enable` from `power_manager`. It stages the switched domain's power-switch segments off and on one segment at a time, reports domain status, and flags isolation/retention protocol violations while any segment is off. Its outputs drive the header-switch chain and feed status back to SoC control.

## Interface
Parameters:
- `N_SEG`, default 4: number of power-switch segments; must be ≥ 2.
- `STEP`, default 4: cycles between successive segment toggles; must be ≥ 1.
- `SETTLE`, default 8: cycles after the last segment turns on before `power_good` asserts; must be ≥ 1.

Ports:
- `clk`  in  1  the only clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `power_switch_enable`  in  1  from `power_manager`; 1 requests domain off, 0 requests domain on.
- `isolation_enable`  in  1  from `power_manager` top level; active-low, so 0 means domain outputs are clamped.
- `state_retention_enable`  in  1  from `power_manager`; 1 means retention is active.
- `seg_on`  out  N_SEG  per-segment switch enable; 1 means the segment conducts.
- `power_good`  out  1  domain fully on and settled.
- `power_off`  out  1  all segments off.
- `iso_err`  out  1  sticky; a segment was off while isolation was not active.
- `ret_err`  out  1  sticky; a segment was off while retention was not active.

## Operation
- All outputs are registered. There is no combinational input-to-output path.
- State machine states: ON, RAMP_DOWN, OFF, RAMP_UP, SETTLE. There is one internal counter, `cnt`, wide enough to hold max(STEP, SETTLE).
- Reset values: state ON, `seg_on` all ones, `power_good`=1, `power_off`=0, `iso_err`=0, `ret_err`=0, `cnt`=0. Reset is the domain POR: all segments go on at once regardless of prior state.
- **ON:** if `power_switch_enable`=1, go to RAMP_DOWN, set `cnt`=0 and `power_good`=0. Otherwise hold.
- **RAMP_DOWN:**
  - If `power_switch_enable`=0, go to RAMP_UP with `cnt`=0 and no segment change on that edge.
  - Otherwise increment `cnt`. When `cnt`=STEP-1, clear the highest-index set bit of `seg_on` and set `cnt`=0.
  - If that clear leaves `seg_on`=0, go to OFF and set `power_off`=1 on the same edge.
- **OFF:** if `power_switch_enable`=0, go to RAMP_UP with `cnt`=0 and `power_off`=0. Otherwise hold.
- **RAMP_UP:**
  - If `power_switch_enable`=1, go to RAMP_DOWN with `cnt`=0 and no segment change on that edge.
  - If `seg_on` is already all ones on entry, go to SETTLE with `cnt`=0 on the next edge.
  - Otherwise increment `cnt`. When `cnt`=STEP-1, set the lowest-index clear bit of `seg_on` and set `cnt`=0.
  - If that set makes `seg_on` all ones, go to SETTLE with `cnt`=0.
- **SETTLE:**
  - If `power_switch_enable`=1, go to RAMP_DOWN with `cnt`=0.
  - Otherwise increment `cnt`. When `cnt`=SETTLE-1, go to ON and set `power_good`=1.
- Segment order is a thermometer code: bits turn off from N_SEG-1 down to 0 and turn on from 0 up to N_SEG-1. A reversal resumes from the current thermometer position.
- Protocol checks are evaluated on each edge against the registered `seg_on` value:
  - If `seg_on` is not all ones and `isolation_enable`=1, set `iso_err`.
  - If `seg_on` is not all ones and `state_retention_enable`=0, set `ret_err`.
  - Both flags clear only on reset. The checks do not alter sequencing.
- Illegal state encodings recover to ON with `seg_on` all ones on the next edge.

## Timing
- Let E0 be the edge that samples `power_switch_enable`=1 in ON.
  - `power_good` falls at E0.
  - The k-th segment turns off at E0 + k·STEP.
  - `seg_on`=0 and `power_off`=1 at E0 + N_SEG·STEP.
- Let E0 be the edge that samples `power_switch_enable`=0 in OFF.
  - `power_off` falls at E0.
  - The k-th segment turns on at E0 + k·STEP.
  - `power_good` rises at E0 + N_SEG·STEP + SETTLE.
- Reversal latency: one edge to switch direction, then the STEP cadence restarts from `cnt`=0.
- A one-cycle request glitch in ON gives: RAMP_DOWN at E0, RAMP_UP at E0+1, SETTLE at E0+2, `power_good` at E0+2+SETTLE. No segment toggles.
- Error flags assert one edge after the violating cycle.

## Test plan
All scenarios use defaults N_SEG=4, STEP=4, SETTLE=8.
- **Power-down:** reset, then hold `isolation_enable`=0 and `state_retention_enable`=1, and raise `power_switch_enable` sampled at E0. Expect `power_good`=0 at E0 and `seg_on`=0111/0011/0001/0000 at E0+4/8/12/16. Expect `power_off`=1 at E0+16 and no errors.
- **Power-up from OFF:** `power_switch_enable`=0 sampled at E0. Expect `power_off`=0 at E0 and `seg_on`=0001/0011/0111/1111 at E0+4/8/12/16. Expect `power_good`=1 at E0+24.
- **Mid-ramp reversal:** request off at E0, then `power_switch_enable`=0 sampled at E0+9 while `seg_on`=0011. Expect 0111 at E0+13, 1111 at E0+17, and `power_good` at E0+25.
- **Protocol violations:** drive `isolation_enable`=1 while `seg_on`=0111, and separately `state_retention_enable`=0 while OFF. Expect `iso_err`/`ret_err`=1 one edge later, held until reset, with sequencing unaffected.
- **Reset mid-operation:** assert `reset` while `seg_on`=0011 in RAMP_DOWN. At the next edge expect `seg_on`=1111, `power_good`=1, `power_off`=0 and errors cleared.
- **Glitch:** a 1-cycle `power_switch_enable` pulse in ON. Expect `seg_on` to stay 1111, `power_good` low from E0, and high again at E0+10.
